physicaloid_stream_arbiter: RTL and testbench

Two-channel Avalon-ST byte-stream arbiter that shares the single host-bound byte stream of the Physicaloid SCIF bridge (its ST sink, `in_*`) between two internal requesters. Whole packets are granted round-robin. When the granted channel differs from the last one sent, a channel-select header is inserted. Payload bytes that collide with the header or escape codes are escaped, so host software can demultiplex the stream.

---
 rtl/physicaloid_stream_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_physicaloid_stream_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/physicaloid_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : physicaloid_stream_arbiter                                 |
// | Description : Two-channel Avalon-ST byte-stream arbiter. It shares the   |
// |               single host-bound byte stream of the Physicaloid SCIF      |
// |               bridge between two requesters. Whole packets are granted   |
// |               round-robin. When framing is enabled, a channel-select     |
// |               header (HDR_CODE, CH_BASE|ch) is inserted whenever the     |
// |               granted channel changes. Payload bytes equal to HDR_CODE   |
// |               or ESC_CODE are sent as ESC_CODE, data^8'h20.              |
// | Config      : `define PHYSICALOID_ARB_FRAMING_EN enables header          |
// |               insertion and escaping. Without it, bytes pass unmodified  |
// |               and the packet-granular round-robin is kept.               |
// | Ports       : clk                  rising-edge clock                     |
// |               reset_n              asynchronous active-low reset         |
// |               chN_valid/data/eop   source byte, N = 0,1                  |
// |               chN_ready            source byte consumed this cycle       |
// |               out_valid/out_data   registered output to bridge in_*      |
// |               out_ready            back-pressure from bridge in_ready    |
// |               grant_ch             channel currently or last granted     |
// |               busy                 FSM is not in ARB                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module physicaloid_stream_arbiter #(
  parameter logic [7:0] HDR_CODE = 8'h7C,
  parameter logic [7:0] ESC_CODE = 8'h7D,
  parameter logic [7:0] CH_BASE  = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ch0_valid,
  input  logic [7:0] ch0_data,
  input  logic       ch0_eop,
  output logic       ch0_ready,
  input  logic       ch1_valid,
  input  logic [7:0] ch1_data,
  input  logic       ch1_eop,
  output logic       ch1_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       grant_ch,
  output logic       busy
);

  localparam logic [2:0] c_ST_ARB  = 3'd0;
  localparam logic [2:0] c_ST_DATA = 3'd3;
`ifdef PHYSICALOID_ARB_FRAMING_EN
  localparam logic [2:0] c_ST_HDR0 = 3'd1;
  localparam logic [2:0] c_ST_HDR1 = 3'd2;
  localparam logic [2:0] c_ST_ESC  = 3'd4;
  localparam logic [7:0] c_ESC_XOR = 8'h20;
`endif

  logic [2:0] r_state;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic       r_grant;
  logic       r_last_ch;

  logic [2:0] w_next_state;
  logic       w_slot_free;
  logic       w_any_req;
  logic       w_pick;
  logic       w_sel_valid;
  logic [7:0] w_sel_data;
  logic       w_sel_eop;
  logic       w_consume;
  logic       w_load;
  logic [7:0] w_load_data;

`ifdef PHYSICALOID_ARB_FRAMING_EN
  logic       r_cur_ch;
  logic       r_cur_vld;
  logic [7:0] r_pend;
  logic       r_pend_eop;
  logic       w_need_esc;
`else
  // Framing codes have no effect in the pass-through build.
  logic       w_unused_cfg;
  assign w_unused_cfg = ^{HDR_CODE, ESC_CODE, CH_BASE};
`endif

  // Output register can take a new byte when empty or draining this cycle.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_any_req   = ch0_valid || ch1_valid;
  // Both requesting: alternate away from the last winner; else the only one.
  assign w_pick      = (ch0_valid && ch1_valid) ? ~r_last_ch : ch1_valid;

  assign w_sel_valid = r_grant ? ch1_valid : ch0_valid;
  assign w_sel_data  = r_grant ? ch1_data  : ch0_data;
  assign w_sel_eop   = r_grant ? ch1_eop   : ch0_eop;
  assign w_consume   = (r_state == c_ST_DATA) && w_slot_free && w_sel_valid;

`ifdef PHYSICALOID_ARB_FRAMING_EN
  assign w_need_esc  = (w_sel_data == HDR_CODE) || (w_sel_data == ESC_CODE);
`endif

  assign ch0_ready = w_consume && !r_grant;
  assign ch1_ready = w_consume &&  r_grant;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign grant_ch  = r_grant;
  assign busy      = (r_state != c_ST_ARB);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_data  = r_out_data;
    case (r_state)
      c_ST_ARB: begin
        if (w_any_req) begin
`ifdef PHYSICALOID_ARB_FRAMING_EN
          // Header is skipped only when the host already selected this channel.
          w_next_state = (r_cur_vld && (w_pick == r_cur_ch)) ? c_ST_DATA : c_ST_HDR0;
`else
          w_next_state = c_ST_DATA;
`endif
        end
      end
`ifdef PHYSICALOID_ARB_FRAMING_EN
      c_ST_HDR0: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_data  = HDR_CODE;
          w_next_state = c_ST_HDR1;
        end
      end
      c_ST_HDR1: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_data  = CH_BASE | {7'd0, r_grant};
          w_next_state = c_ST_DATA;
        end
      end
      c_ST_ESC: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_data  = r_pend;
          w_next_state = r_pend_eop ? c_ST_ARB : c_ST_DATA;
        end
      end
`endif
      c_ST_DATA: begin
        if (w_consume) begin
          w_load = 1'b1;
`ifdef PHYSICALOID_ARB_FRAMING_EN
          if (w_need_esc) begin
            w_load_data  = ESC_CODE;
            w_next_state = c_ST_ESC;
          end else begin
            w_load_data = w_sel_data;
            if (w_sel_eop) begin
              w_next_state = c_ST_ARB;
            end
          end
`else
          w_load_data = w_sel_data;
          if (w_sel_eop) begin
            w_next_state = c_ST_ARB;
          end
`endif
        end
      end
      default: w_next_state = c_ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_ST_ARB;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_grant     <= 1'b0;
      r_last_ch   <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if ((r_state == c_ST_ARB) && w_any_req) begin
        r_grant   <= w_pick;
        r_last_ch <= w_pick;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef PHYSICALOID_ARB_FRAMING_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_ch   <= 1'b0;
      r_cur_vld  <= 1'b0;
      r_pend     <= 8'h00;
      r_pend_eop <= 1'b0;
    end else begin
      if ((r_state == c_ST_HDR1) && w_slot_free) begin
        r_cur_ch  <= r_grant;
        r_cur_vld <= 1'b1;
      end
      if (w_consume && w_need_esc) begin
        r_pend     <= w_sel_data ^ c_ESC_XOR;
        r_pend_eop <= w_sel_eop;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_physicaloid_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_physicaloid_stream_arbiter                              |
// | Description : Self-checking bench for physicaloid_stream_arbiter.        |
// |               Expectations follow PHYSICALOID_ARB_FRAMING_EN.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_physicaloid_stream_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ch0_valid, ch0_eop, ch0_ready;
  logic       ch1_valid, ch1_eop, ch1_ready;
  logic [7:0] ch0_data, ch1_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       grant_ch, busy;

  always #5 clk = ~clk;

  physicaloid_stream_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ch0_valid (ch0_valid),
    .ch0_data  (ch0_data),
    .ch0_eop   (ch0_eop),
    .ch0_ready (ch0_ready),
    .ch1_valid (ch1_valid),
    .ch1_data  (ch1_data),
    .ch1_eop   (ch1_eop),
    .ch1_ready (ch1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_ch  (grant_ch),
    .busy      (busy)
  );

  typedef struct {
    logic       c0v;
    logic [7:0] c0d;
    logic       c0e;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       rdy0;
    logic       bsy;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       rdy_pat[$];
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic c0v, input logic [7:0] c0d, input logic c0e,
                         input logic ordy, input logic ov, input logic [7:0] od,
                         input logic rdy0, input logic bsy);
    vec_t v;
    v.c0v = c0v; v.c0d = c0d; v.c0e = c0e; v.ordy = ordy;
    v.ov = ov; v.od = od; v.rdy0 = rdy0; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  // One clock: drive sources from the queues, sample away from the edge,
  // record accepted output bytes and retire consumed source bytes.
  task automatic step();
    @(negedge clk);
    ch0_valid = (q0.size() > 0);
    ch0_data  = ch0_valid ? q0[0][7:0] : 8'h00;
    ch0_eop   = ch0_valid ? q0[0][8]   : 1'b0;
    ch1_valid = (q1.size() > 0);
    ch1_data  = ch1_valid ? q1[0][7:0] : 8'h00;
    ch1_eop   = ch1_valid ? q1[0][8]   : 1'b0;
    out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    #1;
    if (prev_stall) begin
      check("stall_hold", 32'({out_valid, out_data}), 32'({1'b1, prev_data}));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) cap.push_back(out_data);
    if (ch0_ready) void'(q0.pop_front());
    if (ch1_ready) void'(q1.pop_front());
  endtask

  task automatic run_until_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      if (q0.size() == 0 && q1.size() == 0 && !busy && !out_valid) done = 1'b1;
    end
    check({name, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string name);
    check({name, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      check($sformatf("%s_b%0d", name, i), 32'(cap[i]), 32'(exp_q[i]));
    end
    cap.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    ch0_valid = 1'b1; ch0_data = 8'h11; ch0_eop = 1'b0;
    ch1_valid = 1'b0; ch1_data = 8'h00; ch1_eop = 1'b0;
    out_ready = 1'b1;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_ch0_ready", 32'(ch0_ready), 32'd0);
    check("rst_ch1_ready", 32'(ch1_ready), 32'd0);
    check("rst_grant",     32'(grant_ch),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    ch0_valid = 1'b0;

    // Cycle-accurate table: ch0 {11, 22 eop} then ch0 {33 eop}.
`ifdef PHYSICALOID_ARB_FRAMING_EN
    add_vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0);
    add_vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b1);
    add_vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b1, 8'h7C, 1'b0, 1'b1);
    add_vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b1, 8'h80, 1'b1, 1'b1);
    add_vec(1'b1, 8'h22, 1'b1, 1'b1,  1'b1, 8'h11, 1'b1, 1'b1);
    add_vec(1'b1, 8'h33, 1'b1, 1'b1,  1'b1, 8'h22, 1'b0, 1'b0);
    add_vec(1'b1, 8'h33, 1'b1, 1'b1,  1'b0, 8'h00, 1'b1, 1'b1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 8'h33, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0);
`else
    add_vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0);
    add_vec(1'b1, 8'h11, 1'b0, 1'b1,  1'b0, 8'h00, 1'b1, 1'b1);
    add_vec(1'b1, 8'h22, 1'b1, 1'b1,  1'b1, 8'h11, 1'b1, 1'b1);
    add_vec(1'b1, 8'h33, 1'b1, 1'b1,  1'b1, 8'h22, 1'b0, 1'b0);
    add_vec(1'b1, 8'h33, 1'b1, 1'b1,  1'b0, 8'h00, 1'b1, 1'b1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 8'h33, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      ch0_valid = tbl[i].c0v;
      ch0_data  = tbl[i].c0d;
      ch0_eop   = tbl[i].c0e;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      check($sformatf("v%0d_ch0_ready", i), 32'(ch0_ready), 32'(tbl[i].rdy0));
      check($sformatf("v%0d_ch1_ready", i), 32'(ch1_ready), 32'd0);
      check($sformatf("v%0d_busy", i),      32'(busy),      32'(tbl[i].bsy));
      check($sformatf("v%0d_grant", i),     32'(grant_ch),  32'd0);
    end

    // Both channels with two 3-byte packets each: strict alternation.
    q0 = '{9'h0A1, 9'h0A2, 9'h1A3, 9'h0A4, 9'h0A5, 9'h1A6};
    q1 = '{9'h0B1, 9'h0B2, 9'h1B3, 9'h0B4, 9'h0B5, 9'h1B6};
`ifdef PHYSICALOID_ARB_FRAMING_EN
    exp_q = '{8'h7C, 8'h81, 8'hB1, 8'hB2, 8'hB3, 8'h7C, 8'h80, 8'hA1, 8'hA2, 8'hA3,
              8'h7C, 8'h81, 8'hB4, 8'hB5, 8'hB6, 8'h7C, 8'h80, 8'hA4, 8'hA5, 8'hA6};
`else
    exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hA1, 8'hA2, 8'hA3,
              8'hB4, 8'hB5, 8'hB6, 8'hA4, 8'hA5, 8'hA6};
`endif
    run_until_idle("rr", 80);
    check_stream("rr");

    // ch1 payload made of the reserved codes.
    q1 = '{9'h07C, 9'h17D};
`ifdef PHYSICALOID_ARB_FRAMING_EN
    exp_q = '{8'h7C, 8'h81, 8'h7D, 8'h5C, 8'h7D, 8'h5D};
`else
    exp_q = '{8'h7C, 8'h7D};
`endif
    run_until_idle("esc", 40);
    check_stream("esc");
    check("esc_grant", 32'(grant_ch), 32'd1);
    check("esc_busy",  32'(busy),     32'd0);

    // Back-pressure in the middle of a ch0 packet.
    q0 = '{9'h031, 9'h032, 9'h133};
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PHYSICALOID_ARB_FRAMING_EN
    exp_q = '{8'h7C, 8'h80, 8'h31, 8'h32, 8'h33};
`else
    exp_q = '{8'h31, 8'h32, 8'h33};
`endif
    run_until_idle("stall", 60);
    check_stream("stall");

    // Reset in the middle of a ch0 packet, then a ch1 packet.
    q0 = '{9'h041, 9'h042, 9'h043, 9'h144};
    repeat (4) step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ch0_ready", 32'(ch0_ready), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_grant",     32'(grant_ch),  32'd0);
    q0.delete();
    cap.delete();
    prev_stall = 1'b0;
    ch0_valid  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q1 = '{9'h1AA};
`ifdef PHYSICALOID_ARB_FRAMING_EN
    exp_q = '{8'h7C, 8'h81, 8'hAA};
`else
    exp_q = '{8'hAA};
`endif
    run_until_idle("post_rst", 40);
    check_stream("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
